// File: rtl/dma_lite_pkg.sv
// Shared register offsets, CR/SR bit positions and FSM state encodings for the
// AXI-Lite DMA control register slave.
package dma_lite_pkg;

    localparam logic [31:0] CR_OFFSET          = 32'h0000_0000;
    localparam logic [31:0] ADDR_OFFSET        = 32'h0000_0008;
    localparam logic [31:0] LENGTH_OFFSET      = 32'h0000_0010;
    localparam logic [31:0] SR_OFFSET_DEFAULT  = 32'h0000_0020;

    localparam int CR_RS_BIT          = 0;
    localparam int CR_IOC_IRQ_EN_BIT  = 12;
    localparam int SR_HALTED_BIT      = 0;
    localparam int SR_IDLE_BIT        = 1;
    localparam int SR_IOC_IRQ_BIT     = 12;
    localparam int LEN_W              = 26;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_CR     = 3'd1,
        SEL_ADDR   = 3'd2,
        SEL_LENGTH = 3'd3,
        SEL_SR     = 3'd4
    } reg_sel_t;

    // The SR offset is a module parameter, so it is passed in rather than fixed here.
    function automatic reg_sel_t decode_offset(input logic [31:0] offset,
                                               input logic [31:0] sr_offset);
        reg_sel_t sel;
        if (offset == CR_OFFSET) begin
            sel = SEL_CR;
        end else if (offset == ADDR_OFFSET) begin
            sel = SEL_ADDR;
        end else if (offset == LENGTH_OFFSET) begin
            sel = SEL_LENGTH;
        end else if (offset == sr_offset) begin
            sel = SEL_SR;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/lite_reg_slave.sv
// AXI-Lite register slave controlling a simple DMA core: CR/ADDR/LENGTH/SR
// registers, start pulse generation and IOC interrupt.
module lite_reg_slave
    import dma_lite_pkg::*;
#(
    parameter int                ADDR_W  = 10,
    parameter logic [ADDR_W-1:0] SR_ADDR = ADDR_W'(SR_OFFSET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
    input  logic              s_axi_lite_awvalid,
    output logic              s_axi_lite_awready,
    input  logic [31:0]       s_axi_lite_wdata,
    input  logic              s_axi_lite_wvalid,
    output logic              s_axi_lite_wready,
    output logic [1:0]        s_axi_lite_bresp,
    output logic              s_axi_lite_bvalid,
    input  logic              s_axi_lite_bready,
    input  logic [ADDR_W-1:0] s_axi_lite_araddr,
    input  logic              s_axi_lite_arvalid,
    output logic              s_axi_lite_arready,
    output logic [31:0]       s_axi_lite_rdata,
    output logic [1:0]        s_axi_lite_rresp,
    output logic              s_axi_lite_rvalid,
    input  logic              s_axi_lite_rready,
    output logic              dma_start,
    output logic [31:0]       dma_addr,
    output logic [LEN_W-1:0]  dma_len,
    input  logic              dma_busy,
    input  logic              dma_done,
    output logic              irq
);

    wr_state_t         wr_state_r;
    rd_state_t         rd_state_r;
    logic              awready_r;
    logic              wready_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic [ADDR_W-1:0] awaddr_q_r;
    logic [31:0]       wdata_q_r;
    logic              arready_r;
    logic              rvalid_r;
    logic [1:0]        rresp_r;
    logic [31:0]       rdata_r;

    logic              cr_rs_r;
    logic              cr_ioc_en_r;
    logic [31:0]       addr_r;
    logic [LEN_W-1:0]  len_r;
    logic              ioc_irq_r;
    logic              start_pending_r;
    logic              dma_start_r;
    logic              irq_r;

    logic              aw_hs_s;
    logic              w_hs_s;
    logic              ar_hs_s;
    logic              wr_commit_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [31:0]       wr_data_s;
    reg_sel_t          wr_sel_s;
    logic [1:0]        wr_resp_s;
    logic              len_trigger_s;
    logic              rs_clear_s;
    logic              sr_w1c_s;
    reg_sel_t          rd_sel_s;
    logic [31:0]       rd_value_s;
    logic [1:0]        rd_resp_s;

    assign aw_hs_s = s_axi_lite_awvalid & awready_r;
    assign w_hs_s  = s_axi_lite_wvalid  & wready_r;
    assign ar_hs_s = s_axi_lite_arvalid & arready_r;

    // Pick the address/data for the commit from the latch or the live bus and decode side effects.
    always_comb begin
        wr_addr_s   = s_axi_lite_awaddr;
        wr_data_s   = s_axi_lite_wdata;
        wr_commit_s = 1'b0;
        if (wr_state_r == W_HAVE_ADDR) begin
            wr_addr_s   = awaddr_q_r;
            wr_commit_s = w_hs_s;
        end else if (wr_state_r == W_HAVE_DATA) begin
            wr_data_s   = wdata_q_r;
            wr_commit_s = aw_hs_s;
        end else if (wr_state_r == W_IDLE) begin
            wr_commit_s = aw_hs_s & w_hs_s;
        end else begin
            wr_commit_s = 1'b0;
        end
        wr_sel_s      = decode_offset(32'(wr_addr_s), 32'(SR_ADDR));
        wr_resp_s     = (wr_sel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        len_trigger_s = wr_commit_s && (wr_sel_s == SEL_LENGTH) && cr_rs_r
                        && (wr_data_s[LEN_W-1:0] != {LEN_W{1'b0}});
        rs_clear_s    = wr_commit_s && (wr_sel_s == SEL_CR) && !wr_data_s[CR_RS_BIT];
        sr_w1c_s      = wr_commit_s && (wr_sel_s == SEL_SR) && wr_data_s[SR_IOC_IRQ_BIT];
    end

    // Write-channel FSM: AW and W may arrive in either order; readies only for the missing half.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_r <= W_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            awaddr_q_r <= {ADDR_W{1'b0}};
            wdata_q_r  <= 32'h0000_0000;
        end else begin
            if (aw_hs_s) begin
                awaddr_q_r <= s_axi_lite_awaddr;
            end
            if (w_hs_s) begin
                wdata_q_r <= s_axi_lite_wdata;
            end
            if (wr_commit_s) begin
                wr_state_r <= W_RESP;
                awready_r  <= 1'b0;
                wready_r   <= 1'b0;
                bvalid_r   <= 1'b1;
                bresp_r    <= wr_resp_s;
            end else begin
                case (wr_state_r)
                    W_IDLE: begin
                        if (aw_hs_s) begin
                            wr_state_r <= W_HAVE_ADDR;
                            awready_r  <= 1'b0;
                            wready_r   <= 1'b1;
                        end else if (w_hs_s) begin
                            wr_state_r <= W_HAVE_DATA;
                            awready_r  <= 1'b1;
                            wready_r   <= 1'b0;
                        end else begin
                            awready_r <= 1'b1;
                            wready_r  <= 1'b1;
                        end
                    end
                    W_HAVE_ADDR: begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                    end
                    W_HAVE_DATA: begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b0;
                    end
                    W_RESP: begin
                        if (s_axi_lite_bready) begin
                            wr_state_r <= W_IDLE;
                            bvalid_r   <= 1'b0;
                            awready_r  <= 1'b1;
                            wready_r   <= 1'b1;
                        end else begin
                            awready_r <= 1'b0;
                            wready_r  <= 1'b0;
                        end
                    end
                    default: begin
                        wr_state_r <= W_IDLE;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b0;
                        bvalid_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register file, start pulse and interrupt; dma_done beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_rs_r         <= 1'b0;
            cr_ioc_en_r     <= 1'b0;
            addr_r          <= 32'h0000_0000;
            len_r           <= {LEN_W{1'b0}};
            ioc_irq_r       <= 1'b0;
            start_pending_r <= 1'b0;
            dma_start_r     <= 1'b0;
            irq_r           <= 1'b0;
        end else begin
            if (wr_commit_s) begin
                case (wr_sel_s)
                    SEL_CR: begin
                        cr_rs_r     <= wr_data_s[CR_RS_BIT];
                        cr_ioc_en_r <= wr_data_s[CR_IOC_IRQ_EN_BIT];
                    end
                    SEL_ADDR:   addr_r <= wr_data_s;
                    SEL_LENGTH: len_r  <= wr_data_s[LEN_W-1:0];
                    default:    ;
                endcase
            end
            start_pending_r <= len_trigger_s;
            dma_start_r     <= start_pending_r && !rs_clear_s;
            if (dma_done) begin
                ioc_irq_r <= 1'b1;
            end else if (sr_w1c_s) begin
                ioc_irq_r <= 1'b0;
            end
            irq_r <= ioc_irq_r & cr_ioc_en_r;
        end
    end

    // Read mux over current register values, so an SR read racing a W1C sees the pre-clear state.
    always_comb begin
        rd_sel_s   = decode_offset(32'(s_axi_lite_araddr), 32'(SR_ADDR));
        rd_value_s = 32'h0000_0000;
        rd_resp_s  = RESP_OKAY;
        case (rd_sel_s)
            SEL_CR: begin
                rd_value_s[CR_RS_BIT]         = cr_rs_r;
                rd_value_s[CR_IOC_IRQ_EN_BIT] = cr_ioc_en_r;
            end
            SEL_ADDR:   rd_value_s              = addr_r;
            SEL_LENGTH: rd_value_s[LEN_W-1:0]   = len_r;
            SEL_SR: begin
                rd_value_s[SR_HALTED_BIT]  = ~cr_rs_r;
                rd_value_s[SR_IDLE_BIT]    = cr_rs_r & ~dma_busy & ~start_pending_r;
                rd_value_s[SR_IOC_IRQ_BIT] = ioc_irq_r;
            end
            default: rd_resp_s = RESP_SLVERR;
        endcase
    end

    // Read-channel FSM: response data is captured at the AR handshake and held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= 32'h0000_0000;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rd_state_r <= R_DATA;
                        arready_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rdata_r    <= rd_value_s;
                        rresp_r    <= rd_resp_s;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_lite_rready) begin
                        rd_state_r <= R_IDLE;
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                    end else begin
                        arready_r <= 1'b0;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_lite_awready = awready_r;
    assign s_axi_lite_wready  = wready_r;
    assign s_axi_lite_bvalid  = bvalid_r;
    assign s_axi_lite_bresp   = bresp_r;
    assign s_axi_lite_arready = arready_r;
    assign s_axi_lite_rvalid  = rvalid_r;
    assign s_axi_lite_rresp   = rresp_r;
    assign s_axi_lite_rdata   = rdata_r;
    assign dma_start          = dma_start_r;
    assign dma_addr           = addr_r;
    assign dma_len            = len_r;
    assign irq                = irq_r;

endmodule

// File: tb/tb_lite_reg_slave.sv
// Randomized and directed bench for lite_reg_slave against a transaction-level register model.
module tb_lite_reg_slave;

    localparam logic [9:0] OFF_CR   = 10'h000;
    localparam logic [9:0] OFF_ADDR = 10'h008;
    localparam logic [9:0] OFF_LEN  = 10'h010;
    localparam logic [9:0] OFF_SR   = 10'h020;
    localparam logic [9:0] OFF_BAD  = 10'h0FC;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  s_axi_lite_awaddr;
    logic        s_axi_lite_awvalid;
    logic        s_axi_lite_awready;
    logic [31:0] s_axi_lite_wdata;
    logic        s_axi_lite_wvalid;
    logic        s_axi_lite_wready;
    logic [1:0]  s_axi_lite_bresp;
    logic        s_axi_lite_bvalid;
    logic        s_axi_lite_bready;
    logic [9:0]  s_axi_lite_araddr;
    logic        s_axi_lite_arvalid;
    logic        s_axi_lite_arready;
    logic [31:0] s_axi_lite_rdata;
    logic [1:0]  s_axi_lite_rresp;
    logic        s_axi_lite_rvalid;
    logic        s_axi_lite_rready;
    logic        dma_start;
    logic [31:0] dma_addr;
    logic [25:0] dma_len;
    logic        dma_busy;
    logic        dma_done;
    logic        irq;

    lite_reg_slave #(.ADDR_W(10), .SR_ADDR(10'h020)) dut (
        .clk(clk), .rst(rst),
        .s_axi_lite_awaddr(s_axi_lite_awaddr), .s_axi_lite_awvalid(s_axi_lite_awvalid),
        .s_axi_lite_awready(s_axi_lite_awready),
        .s_axi_lite_wdata(s_axi_lite_wdata), .s_axi_lite_wvalid(s_axi_lite_wvalid),
        .s_axi_lite_wready(s_axi_lite_wready),
        .s_axi_lite_bresp(s_axi_lite_bresp), .s_axi_lite_bvalid(s_axi_lite_bvalid),
        .s_axi_lite_bready(s_axi_lite_bready),
        .s_axi_lite_araddr(s_axi_lite_araddr), .s_axi_lite_arvalid(s_axi_lite_arvalid),
        .s_axi_lite_arready(s_axi_lite_arready),
        .s_axi_lite_rdata(s_axi_lite_rdata), .s_axi_lite_rresp(s_axi_lite_rresp),
        .s_axi_lite_rvalid(s_axi_lite_rvalid), .s_axi_lite_rready(s_axi_lite_rready),
        .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_done(dma_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Register model (state as seen after the most recent clock edge)
    logic        m_rs, m_en, m_ioc, m_pending, m_start, m_irq;
    logic [31:0] m_addr;
    logic [25:0] m_len;
    logic        m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    // Driver state
    logic        wr_active, aw_done, w_done, rd_active, ar_done;
    int          aw_wait, w_wait, ar_wait;
    logic [9:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    int          bready_mode, rready_mode;
    logic        done_req, busy_val;

    int          cyc, w_hs_cyc, b_rise_cyc, dut_starts;
    logic        prev_bv;
    logic [1:0]  last_bresp, last_rresp;
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_mapped(input logic [9:0] a);
        return (a == OFF_CR) || (a == OFF_ADDR) || (a == OFF_LEN) || (a == OFF_SR);
    endfunction

    // Returns {resp, data} for a read of offset a given the present model state.
    function automatic logic [33:0] m_read(input logic [9:0] a, input logic busy);
        logic [31:0] d;
        d = 32'h0;
        if (a == OFF_CR)        d = (m_en ? 32'h1000 : 32'h0) + (m_rs ? 32'h1 : 32'h0);
        else if (a == OFF_ADDR) d = m_addr;
        else if (a == OFF_LEN)  d = {6'd0, m_len};
        else if (a == OFF_SR)   d = (m_ioc ? 32'h1000 : 32'h0)
                                  + ((m_rs && !busy && !m_pending) ? 32'h2 : 32'h0)
                                  + (m_rs ? 32'h0 : 32'h1);
        return {(is_mapped(a) ? 2'b00 : 2'b10), d};
    endfunction

    task automatic model_reset();
        {m_rs, m_en, m_ioc, m_pending, m_start, m_irq} = 6'b0;
        m_addr = 32'h0; m_len = 26'h0;
        m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
        wr_active = 1'b0; aw_done = 1'b0; w_done = 1'b0; rd_active = 1'b0; ar_done = 1'b0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        done_req = 1'b0; busy_val = 1'b0; prev_bv = 1'b0;
        s_axi_lite_awvalid = 1'b0; s_axi_lite_wvalid = 1'b0; s_axi_lite_arvalid = 1'b0;
        s_axi_lite_bready = 1'b0; s_axi_lite_rready = 1'b0;
        s_axi_lite_awaddr = 10'h0; s_axi_lite_wdata = 32'h0; s_axi_lite_araddr = 10'h0;
        dma_done = 1'b0; dma_busy = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_awready"}, 32'(s_axi_lite_awready), 32'h0);
        check({tag, "_wready"},  32'(s_axi_lite_wready),  32'h0);
        check({tag, "_bvalid"},  32'(s_axi_lite_bvalid),  32'h0);
        check({tag, "_bresp"},   32'(s_axi_lite_bresp),   32'h0);
        check({tag, "_arready"}, 32'(s_axi_lite_arready), 32'h0);
        check({tag, "_rvalid"},  32'(s_axi_lite_rvalid),  32'h0);
        check({tag, "_rresp"},   32'(s_axi_lite_rresp),   32'h0);
        check({tag, "_rdata"},   s_axi_lite_rdata,        32'h0);
        check({tag, "_start"},   32'(dma_start),          32'h0);
        check({tag, "_irq"},     32'(irq),                32'h0);
        check({tag, "_addr"},    dma_addr,                32'h0);
        check({tag, "_len"},     32'(dma_len),            32'h0);
    endtask

    // One clock: compare outputs at the negedge, drive inputs, then advance the model over the coming edge.
    task automatic cycle();
        logic aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, trigger, rs_clear;
        logic [33:0] rd;
        @(negedge clk);
        cyc++;
        check("bvalid", 32'(s_axi_lite_bvalid), 32'(m_bvalid));
        if (m_bvalid) check("bresp", 32'(s_axi_lite_bresp), 32'(m_bresp));
        check("rvalid", 32'(s_axi_lite_rvalid), 32'(m_rvalid));
        if (m_rvalid) begin
            check("rdata", s_axi_lite_rdata, m_rdata);
            check("rresp", 32'(s_axi_lite_rresp), 32'(m_rresp));
        end
        check("dma_addr", dma_addr, m_addr);
        check("dma_len", 32'(dma_len), 32'(m_len));
        check("dma_start", 32'(dma_start), 32'(m_start));
        check("irq", 32'(irq), 32'(m_irq));
        if (m_bvalid || (wr_active && aw_done)) check("awready_low", 32'(s_axi_lite_awready), 32'h0);
        if (m_bvalid || (wr_active && w_done))  check("wready_low", 32'(s_axi_lite_wready), 32'h0);
        if (m_rvalid) check("arready_low", 32'(s_axi_lite_arready), 32'h0);
        if (s_axi_lite_bvalid && !prev_bv) b_rise_cyc = cyc;
        prev_bv = s_axi_lite_bvalid;
        if (dma_start) dut_starts++;

        s_axi_lite_awvalid = wr_active && !aw_done && (aw_wait == 0);
        s_axi_lite_wvalid  = wr_active && !w_done && (w_wait == 0);
        s_axi_lite_arvalid = rd_active && !ar_done && (ar_wait == 0);
        s_axi_lite_awaddr  = wr_addr;
        s_axi_lite_wdata   = wr_data;
        s_axi_lite_araddr  = rd_addr;
        if (aw_wait > 0) aw_wait--;
        if (w_wait > 0) w_wait--;
        if (ar_wait > 0) ar_wait--;
        s_axi_lite_bready = (bready_mode == 0) ? 1'($urandom_range(1)) : (bready_mode == 1);
        s_axi_lite_rready = (rready_mode == 0) ? 1'($urandom_range(1)) : (rready_mode == 1);
        dma_done = done_req;
        dma_busy = busy_val;
        if (s_axi_lite_bvalid && s_axi_lite_bready) last_bresp = s_axi_lite_bresp;
        if (s_axi_lite_rvalid && s_axi_lite_rready) begin
            last_rdata = s_axi_lite_rdata;
            last_rresp = s_axi_lite_rresp;
        end

        aw_hs  = s_axi_lite_awvalid && s_axi_lite_awready;
        w_hs   = s_axi_lite_wvalid && s_axi_lite_wready;
        ar_hs  = s_axi_lite_arvalid && s_axi_lite_arready;
        b_hs   = m_bvalid && s_axi_lite_bready;
        r_hs   = m_rvalid && s_axi_lite_rready;
        if (w_hs) w_hs_cyc = cyc;
        commit = wr_active && !m_bvalid && (aw_done || aw_hs) && (w_done || w_hs);
        rd = m_read(rd_addr, busy_val);
        trigger  = commit && (wr_addr == OFF_LEN) && m_rs && (wr_data[25:0] != 26'd0);
        rs_clear = commit && (wr_addr == OFF_CR) && !wr_data[0];

        m_irq     = m_ioc && m_en;
        m_start   = m_pending && !rs_clear;
        m_pending = trigger;
        if (dma_done) m_ioc = 1'b1;
        else if (commit && (wr_addr == OFF_SR) && wr_data[12]) m_ioc = 1'b0;
        if (commit) begin
            if (wr_addr == OFF_CR) begin
                m_rs = wr_data[0];
                m_en = wr_data[12];
            end else if (wr_addr == OFF_ADDR) begin
                m_addr = wr_data;
            end else if (wr_addr == OFF_LEN) begin
                m_len = wr_data[25:0];
            end
            m_bvalid = 1'b1;
            m_bresp  = is_mapped(wr_addr) ? 2'b00 : 2'b10;
        end else if (b_hs) begin
            m_bvalid  = 1'b0;
            wr_active = 1'b0;
        end
        if (ar_hs) begin
            m_rvalid = 1'b1;
            m_rdata  = rd[31:0];
            m_rresp  = rd[33:32];
            ar_done  = 1'b1;
        end else if (r_hs) begin
            m_rvalid  = 1'b0;
            rd_active = 1'b0;
        end
        if (aw_hs) aw_done = 1'b1;
        if (w_hs) w_done = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_write(input logic [9:0] a, input logic [31:0] d, input int awd, input int wd);
        wr_active = 1'b1; aw_done = 1'b0; w_done = 1'b0;
        wr_addr = a; wr_data = d; aw_wait = awd; w_wait = wd;
    endtask

    task automatic start_read(input logic [9:0] a, input int ard);
        rd_active = 1'b1; ar_done = 1'b0; rd_addr = a; ar_wait = ard;
    endtask

    task automatic wait_write();
        for (int i = 0; i < 60 && wr_active; i++) cycle();
        if (wr_active) begin
            checks++; errors++;
            $display("FAIL write_timeout: transaction to 0x%03h still open, required done", wr_addr);
            wr_active = 1'b0; m_bvalid = 1'b0;
        end
    endtask

    task automatic wait_read();
        for (int i = 0; i < 60 && rd_active; i++) cycle();
        if (rd_active) begin
            checks++; errors++;
            $display("FAIL read_timeout: transaction to 0x%03h still open, required done", rd_addr);
            rd_active = 1'b0; m_rvalid = 1'b0;
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d);
        start_write(a, d, 0, 0);
        wait_write();
    endtask

    task automatic do_read(input logic [9:0] a);
        start_read(a, 0);
        wait_read();
    endtask

    initial begin
        logic [9:0]  rnd_addr;
        logic [31:0] rnd_data;
        int          s0;
        cyc = 0; dut_starts = 0; w_hs_cyc = 0; b_rise_cyc = 0;
        last_bresp = 2'b00; last_rresp = 2'b00; last_rdata = 32'h0;
        bready_mode = 1; rready_mode = 1;
        rst = 1'b0;
        model_reset();
        #1;
        reset_checks("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ADDR written with W two cycles behind AW
        start_write(OFF_ADDR, 32'h1000_0000, 0, 2);
        wait_write();
        check("wr_b_latency", 32'(b_rise_cyc - w_hs_cyc), 32'd1);
        check("wr_addr_bresp", 32'(last_bresp), 32'h0);
        check("wr_addr_value", dma_addr, 32'h1000_0000);

        // Start a transfer and read SR while the core is busy
        do_write(OFF_CR, 32'h0000_0001);
        s0 = dut_starts;
        do_write(OFF_LEN, 32'h0000_0100);
        idle(3);
        check("start_pulses", 32'(dut_starts - s0), 32'd1);
        check("len_value", 32'(dma_len), 32'h100);
        busy_val = 1'b1;
        do_read(OFF_SR);
        check("sr_busy", last_rdata, 32'h0);
        busy_val = 1'b0;

        // Unmapped offset
        do_read(OFF_BAD);
        check("bad_rdata", last_rdata, 32'h0);
        check("bad_rresp", 32'(last_rresp), 32'h2);
        do_write(OFF_BAD, 32'hFFFF_FFFF);
        check("bad_bresp", 32'(last_bresp), 32'h2);
        check("bad_no_addr_change", dma_addr, 32'h1000_0000);
        check("bad_no_len_change", 32'(dma_len), 32'h100);

        // Interrupt, then W1C racing a second dma_done
        do_write(OFF_CR, 32'h0000_1001);
        done_req = 1'b1;
        cycle();
        done_req = 1'b0;
        idle(3);
        check("irq_set", 32'(irq), 32'h1);
        start_write(OFF_SR, 32'h0000_1000, 0, 0);
        done_req = 1'b1;
        cycle();
        done_req = 1'b0;
        wait_write();
        idle(3);
        check("irq_set_wins", 32'(irq), 32'h1);
        do_read(OFF_SR);
        check("sr_ioc_bit", 32'(last_rdata[12]), 32'h1);
        do_write(OFF_SR, 32'h0000_1000);
        idle(3);
        check("irq_cleared", 32'(irq), 32'h0);

        // Back-pressure on both response channels
        bready_mode = 2; rready_mode = 2;
        start_write(OFF_ADDR, 32'hABCD_0000, 0, 0);
        start_read(OFF_CR, 0);
        idle(8);
        check("bp_bvalid", 32'(s_axi_lite_bvalid), 32'h1);
        check("bp_rvalid", 32'(s_axi_lite_rvalid), 32'h1);
        check("bp_awready", 32'(s_axi_lite_awready), 32'h0);
        check("bp_arready", 32'(s_axi_lite_arready), 32'h0);
        check("bp_rdata", s_axi_lite_rdata, 32'h0000_1001);
        bready_mode = 1; rready_mode = 1;
        wait_write();
        wait_read();

        // Randomized concurrent traffic
        bready_mode = 0; rready_mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!wr_active && ($urandom_range(3) == 0)) begin
                case ($urandom_range(6))
                    0: rnd_addr = OFF_CR;
                    1: rnd_addr = OFF_ADDR;
                    2: rnd_addr = OFF_LEN;
                    3: rnd_addr = OFF_SR;
                    4: rnd_addr = OFF_BAD;
                    default: rnd_addr = 10'($urandom);
                endcase
                rnd_data = $urandom;
                if ($urandom_range(3) == 0) rnd_data = 32'h0;
                start_write(rnd_addr, rnd_data, $urandom_range(3), $urandom_range(3));
            end
            if (!rd_active && ($urandom_range(2) == 0)) begin
                case ($urandom_range(5))
                    0: rnd_addr = OFF_CR;
                    1: rnd_addr = OFF_ADDR;
                    2: rnd_addr = OFF_LEN;
                    3: rnd_addr = OFF_SR;
                    4: rnd_addr = OFF_SR;
                    default: rnd_addr = 10'($urandom);
                endcase
                start_read(rnd_addr, $urandom_range(2));
            end
            done_req = ($urandom_range(9) == 0);
            if ($urandom_range(7) == 0) busy_val = ~busy_val;
            cycle();
        end
        done_req = 1'b0;
        bready_mode = 1; rready_mode = 1;
        wait_write();
        wait_read();

        // Reset with AW accepted and W still pending
        start_write(OFF_ADDR, 32'h5555_0000, 0, 20);
        idle(3);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_write(OFF_LEN, 32'h0000_0055);
        check("post_rst_bresp", 32'(last_bresp), 32'h0);
        check("post_rst_len", 32'(dma_len), 32'h55);
        check("post_rst_addr", dma_addr, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
